// File: rtl/fixed_to_fp16_encoder.sv
// Signed fixed-point to IEEE fp16 encoder, 2-stage elastic pipeline (S1: sign/abs/lead-one, S2: round/pack).
// Latency 2, 1 beat/cycle; stalls propagate back via data_in_ready. Define FP16_ENC_RNE_EN for round-to-nearest-even.
module fixed_to_fp16_encoder #(
  parameter int IN_WIDTH    = 32,
  parameter int FRAC_WIDTH  = 16,
  parameter int OUTLIER_EXP = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] data_in,
  input  logic                data_in_valid,
  output logic                data_in_ready,
  output logic [15:0]         data_out,
  output logic                data_out_outlier,
  output logic                data_out_valid,
  input  logic                data_out_ready
);

  localparam int PW = $clog2(IN_WIDTH);

  logic                s1_vld_q, s1_vld_d;
  logic                s1_sign_q, s1_sign_d;
  logic [IN_WIDTH-1:0] s1_abs_q, s1_abs_d;
  logic [PW-1:0]       s1_pos_q, s1_pos_d;
  logic                s2_vld_q, s2_vld_d;
  logic                s2_outlier_q, s2_outlier_d;
  logic [15:0]         s2_dat_q, s2_dat_d;

  logic s1_adv, s2_adv;

  assign s2_adv        = !s2_vld_q || data_out_ready;
  assign s1_adv        = !s1_vld_q || s2_adv;
  assign data_in_ready = !rst && s1_adv;

  assign data_out         = s2_dat_q;
  assign data_out_outlier = s2_outlier_q;
  assign data_out_valid   = s2_vld_q;

  logic [IN_WIDTH-1:0] abs_c;
  logic [PW-1:0]       pos_c;

  always_comb begin
    // Unsigned magnitude: the most-negative input maps to 2^(IN_WIDTH-1) exactly.
    abs_c = data_in[IN_WIDTH-1] ? (~data_in + IN_WIDTH'(1)) : data_in;
    pos_c = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (abs_c[i]) pos_c = PW'(i);
    end
    s1_vld_d  = s1_vld_q;
    s1_sign_d = s1_sign_q;
    s1_abs_d  = s1_abs_q;
    s1_pos_d  = s1_pos_q;
    if (s1_adv) begin
      s1_vld_d = data_in_valid;
      if (data_in_valid) begin
        s1_sign_d = data_in[IN_WIDTH-1];
        s1_abs_d  = abs_c;
        s1_pos_d  = pos_c;
      end
    end
  end

  logic [IN_WIDTH-1:0] norm;
  logic [9:0]          mant_t;
  logic [10:0]         mant_r;
  int                  exp_c;
  logic [15:0]         dat_c;
  logic                outl_c;
`ifdef FP16_ENC_RNE_EN
  localparam logic [IN_WIDTH-1:0] STICKY_MASK = (IN_WIDTH'(1) << (IN_WIDTH - 12)) - IN_WIDTH'(1);
  logic guard, sticky;
`endif

  always_comb begin
    // Leading one moved to the MSB; a clear MSB therefore means a zero input.
    norm   = s1_abs_q << (IN_WIDTH - 1 - int'(s1_pos_q));
    mant_t = 10'(norm >> (IN_WIDTH - 11));
    exp_c  = int'(s1_pos_q) - FRAC_WIDTH + 15;
`ifdef FP16_ENC_RNE_EN
    guard  = norm[IN_WIDTH-12];
    sticky = |(norm & STICKY_MASK);
    mant_r = {1'b0, mant_t} + 11'(guard & (sticky | mant_t[0]));
`else
    mant_r = {1'b0, mant_t};
`endif
    if (mant_r[10]) exp_c = exp_c + 1;
    dat_c  = '0;
    outl_c = 1'b0;
    if (norm[IN_WIDTH-1] && exp_c > 0) begin
      if (exp_c >= 31) begin
        dat_c  = {s1_sign_q, 15'h7BFF};
        outl_c = (30 >= 15 + OUTLIER_EXP);
      end else begin
        dat_c  = {s1_sign_q, exp_c[4:0], mant_r[9:0]};
        outl_c = (exp_c >= 15 + OUTLIER_EXP);
      end
    end
    s2_vld_d     = s2_vld_q;
    s2_dat_d     = s2_dat_q;
    s2_outlier_d = s2_outlier_q;
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_d     = dat_c;
        s2_outlier_d = outl_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_abs_q     <= '0;
      s1_pos_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_dat_q     <= '0;
      s2_outlier_q <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_sign_q    <= s1_sign_d;
      s1_abs_q     <= s1_abs_d;
      s1_pos_q     <= s1_pos_d;
      s2_vld_q     <= s2_vld_d;
      s2_dat_q     <= s2_dat_d;
      s2_outlier_q <= s2_outlier_d;
    end
  end

endmodule

// File: doc/fixed_to_fp16_encoder.md
FIXED_TO_FP16_ENCODER -- requirements
Module: fixed_to_fp16_encoder

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: width of the signed two's-complement input; legal range 12..64.
REQ-002 SHALL have parameter FRAC_WIDTH, default 16: number of fractional input bits, so value = data_in / 2^FRAC_WIDTH; legal range 0..IN_WIDTH-1.
REQ-003 SHALL have parameter OUTLIER_EXP, default 3: unbiased-exponent threshold for the outlier flag.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port data_in, input, IN_WIDTH bits: fixed-point sample.
REQ-007 SHALL have port data_in_valid, input, 1 bit: the upstream beat is valid.
REQ-008 SHALL have port data_in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 SHALL have port data_out, output, 16 bits: IEEE fp16 result, laid out as sign [15], exponent [14:10] and mantissa [9:0].
REQ-010 SHALL have port data_out_outlier, output, 1 bit: data_out's biased exponent is >= 15+OUTLIER_EXP.
REQ-011 SHALL have port data_out_valid, output, 1 bit: the output beat is valid.
REQ-012 SHALL have port data_out_ready, input, 1 bit: downstream accepts the beat.

Function
REQ-013 SHALL be a 2-stage elastic pipeline: S1 = sign, absolute value, leading-one position; S2 = normalise, round, pack, flag.
REQ-014 SHALL transfer a beat on any edge where valid and ready are both high; with no stalls, latency is 2 cycles from input handshake to data_out_valid, at 1 beat/cycle throughput.
REQ-015 SHALL register the stage-advance condition as: stage advances iff it is empty or the next stage advances; data_in_ready = S1 empty OR S1 advances (combinational path from data_out_ready allowed).
REQ-016 SHALL hold data_out, data_out_outlier and data_out_valid stable while data_out_valid=1 and data_out_ready=0; no beats are lost, duplicated or reordered.
REQ-017 SHALL compute the absolute value in IN_WIDTH unsigned bits; the most-negative input -2^(IN_WIDTH-1) SHALL encode correctly with sign=1.
REQ-018 SHALL set the biased exponent E = p - FRAC_WIDTH + 15, where p is the leading-one bit index; mantissa = the 10 bits below the leading one, zero-padded when p<10.
REQ-019 SHALL output 0x0000 for input 0 (no negative zero).
REQ-020 SHALL flush results with E<=0 to 0x0000; the sign is dropped and subnormals are not produced.
REQ-021 SHALL saturate results with E>=31, including after a rounding carry, to 0x7BFF (positive) or 0xFBFF (negative); Inf/NaN are never produced.
REQ-022 SHALL increment E and zero the mantissa when a rounding carry propagates out of the mantissa.
REQ-023 SHALL compute data_out_outlier from the final packed exponent, after rounding and saturation; a flushed zero gives flag 0.

Reset
REQ-024 SHALL, while rst=1, clear both stage-valid flags asynchronously: data_out_valid=0, data_out=0x0000, data_out_outlier=0, data_in_ready=0.
REQ-025 SHALL set data_in_ready=1 on the first cycle after rst deasserts; in-flight beats at reset assertion are discarded.

Configuration
REQ-026 SHALL use macro FP16_ENC_RNE_EN: when defined, the mantissa rounds to nearest, ties to even, using guard and sticky bits from the discarded low bits; when undefined, the mantissa truncates toward zero in magnitude and no rounding carry occurs.

Verification (IN_WIDTH=32, FRAC_WIDTH=16 unless stated)
REQ-027 SHALL cover: 0x00010000 -> 0x3C00, outlier 0; 0x00080000 -> 0x4800, outlier 1; 0xFFFD8000 -> 0xC100, outlier 0; 0x00000000 -> 0x0000; 0x80000000 -> 0xF800, outlier 1.
REQ-028 SHALL cover rounding: 0x00010020 -> 0x3C00 in both modes (tie to even); 0x00010030 -> 0x3C01 with FP16_ENC_RNE_EN, 0x3C00 without; 0x7FFFFFFF -> 0x7800 with RNE (carry into exponent), 0x77FF without.
REQ-029 SHALL cover flush and saturate: 0x00000001 -> 0x0000; with FRAC_WIDTH=0, 0x00010000 -> 0x7BFF and 0xFFFF0000 -> 0xFBFF.
REQ-030 SHALL cover backpressure: stream 5 beats with data_out_ready low for 4 cycles -> data_in_ready falls after 2 accepted beats, output held stable, and all 5 results emerge in order once ready returns.
REQ-031 SHALL cover reset mid-stream: assert rst with both stages full -> data_out_valid falls the same cycle without a clock edge, and no stale beat appears after release.
REQ-032 SHALL cover throughput: continuous valid with data_out_ready=1 for 100 beats -> 100 outputs in 101 cycles, each matching a reference model.
